// File: rtl/dead_time_pkg.sv
// Shared leg-state encoding and defaults for the dead-time inserter.
// Optional build macro DTI_FAULT_LATCH_EN is consumed by dead_time_inserter.
package dead_time_pkg;

    localparam int DT_WIDTH_DEFAULT = 8;

    typedef logic [2:0] leg_state_t;

    localparam leg_state_t IDLE    = 3'd0;
    localparam leg_state_t DEAD_HI = 3'd1;
    localparam leg_state_t HI_ON   = 3'd2;
    localparam leg_state_t DEAD_LO = 3'd3;
    localparam leg_state_t LO_ON   = 3'd4;

    // Dead state that precedes the gate the comparator currently asks for.
    function automatic leg_state_t dead_target(input logic want_hi);
        return want_hi ? DEAD_HI : DEAD_LO;
    endfunction

endpackage

// File: rtl/dead_time_inserter_leg.sv
// One inverter leg: dead-time FSM, down-counter and registered gate pair.
// Gates decode the next state, so a gate drops on the same edge the leg leaves its ON state.
module dead_time_leg
    import dead_time_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_enable,
    input  logic                force_idle,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                cmp_in,
    output logic                gate_hi,
    output logic                gate_lo
);

    leg_state_t          state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                gate_hi_q, gate_hi_d;
    logic                gate_lo_q, gate_lo_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (force_idle) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (clk_enable) begin
            case (state_q)
                IDLE: begin
                    cnt_d   = dead_time;
                    state_d = dead_target(cmp_in);
                end
                DEAD_HI: begin
                    // A reversal mid-interval restarts the full dead time toward the other side.
                    if (!cmp_in) begin
                        cnt_d   = dead_time;
                        state_d = DEAD_LO;
                    end else if (cnt_q == '0) begin
                        state_d = HI_ON;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                HI_ON: begin
                    if (!cmp_in) begin
                        cnt_d   = dead_time;
                        state_d = DEAD_LO;
                    end
                end
                DEAD_LO: begin
                    if (cmp_in) begin
                        cnt_d   = dead_time;
                        state_d = DEAD_HI;
                    end else if (cnt_q == '0) begin
                        state_d = LO_ON;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                LO_ON: begin
                    if (cmp_in) begin
                        cnt_d   = dead_time;
                        state_d = DEAD_HI;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        gate_hi_d = (state_d == HI_ON);
        gate_lo_d = (state_d == LO_ON);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    assign gate_hi = gate_hi_q;
    assign gate_lo = gate_lo_q;

endmodule

// File: rtl/dead_time_inserter.sv
// Complementary gate-pair generator with programmable dead time for NUM_LEGS inverter legs.
// Define DTI_FAULT_LATCH_EN to latch fault_active until fault_clr; otherwise it tracks fault.
module dead_time_inserter
    import dead_time_pkg::*;
#(
    parameter int NUM_LEGS = 3,
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_enable,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic [NUM_LEGS-1:0] cmp_in,
    input  logic                fault,
    input  logic                fault_clr,
    output logic [NUM_LEGS-1:0] gate_hi,
    output logic [NUM_LEGS-1:0] gate_lo,
    output logic                fault_active
);

    logic fault_active_q, fault_active_d;

`ifdef DTI_FAULT_LATCH_EN
    always_comb begin
        fault_active_d = fault | (fault_active_q & ~fault_clr);
    end
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;

    always_comb begin
        fault_active_d = fault;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fault_active_q <= 1'b0;
        end else begin
            fault_active_q <= fault_active_d;
        end
    end

    assign fault_active = fault_active_q;

    // Legs see the post-edge fault status, so they go IDLE on the same edge it asserts.
    for (genvar i = 0; i < NUM_LEGS; i++) begin : g_leg
        dead_time_leg #(
            .DT_WIDTH(DT_WIDTH)
        ) u_leg (
            .clk       (clk),
            .reset_n   (reset_n),
            .clk_enable(clk_enable),
            .force_idle(fault_active_d),
            .dead_time (dead_time),
            .cmp_in    (cmp_in[i]),
            .gate_hi   (gate_hi[i]),
            .gate_lo   (gate_lo[i])
        );
    end

endmodule

// File: tb/tb_dead_time_inserter.sv
// Table-driven bench for dead_time_inserter with a scoreboard queue and a gate-overlap monitor.
// Honours DTI_FAULT_LATCH_EN when choosing fault-release expectations.
module tb_dead_time_inserter;

    localparam int NUM_LEGS = 3;
    localparam int DT_WIDTH = 8;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                clk_enable;
    logic [DT_WIDTH-1:0] dead_time;
    logic [NUM_LEGS-1:0] cmp_in;
    logic                fault;
    logic                fault_clr;
    logic [NUM_LEGS-1:0] gate_hi;
    logic [NUM_LEGS-1:0] gate_lo;
    logic                fault_active;

    always #5 clk = ~clk;

    dead_time_inserter #(
        .NUM_LEGS(NUM_LEGS),
        .DT_WIDTH(DT_WIDTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_enable  (clk_enable),
        .dead_time   (dead_time),
        .cmp_in      (cmp_in),
        .fault       (fault),
        .fault_clr   (fault_clr),
        .gate_hi     (gate_hi),
        .gate_lo     (gate_lo),
        .fault_active(fault_active)
    );

    typedef struct packed {
        logic       rst_n;
        logic       en;
        logic       flt;
        logic       clr;
        logic [7:0] dt;
        logic [2:0] cmp;
        logic [2:0] ehi;
        logic [2:0] elo;
        logic       efa;
    } vec_t;

    typedef struct packed {
        logic [2:0] hi;
        logic [2:0] lo;
        logic       fa;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;
    bit   inv_on = 1'b0;

    function automatic vec_t mk(input int r, input int e, input int f, input int c,
                                input int d, input int cm, input int h, input int l,
                                input int fa);
        vec_t t;
        t.rst_n = r[0];
        t.en    = e[0];
        t.flt   = f[0];
        t.clr   = c[0];
        t.dt    = d[7:0];
        t.cmp   = cm[2:0];
        t.ehi   = h[2:0];
        t.elo   = l[2:0];
        t.efa   = fa[0];
        return t;
    endfunction

    task automatic check_val(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d actual %b required %b", name, step, act, req);
        end
    endtask

    // Drive one vector, queue its expectation, then compare after the edge.
    task automatic apply(input vec_t t);
        exp_t e;
        @(negedge clk);
        reset_n    = t.rst_n;
        clk_enable = t.en;
        fault      = t.flt;
        fault_clr  = t.clr;
        dead_time  = t.dt;
        cmp_in     = t.cmp;
        e.hi = t.ehi;
        e.lo = t.elo;
        e.fa = t.efa;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step++;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty step %0d actual 0 required 1", step);
        end else begin
            e = sb_q.pop_front();
            check_val("gate_hi", gate_hi, e.hi);
            check_val("gate_lo", gate_lo, e.lo);
            check_val("fault_active", {2'b00, fault_active}, {2'b00, e.fa});
        end
    endtask

    always @(negedge clk) begin
        if (inv_on) begin
            checks++;
            if ((gate_hi & gate_lo) !== 3'b000) begin
                errors++;
                $display("FAIL overlap actual hi %b lo %b required no common bit", gate_hi, gate_lo);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        clk_enable = 1'b1;
        fault      = 1'b0;
        fault_clr  = 1'b0;
        dead_time  = '0;
        cmp_in     = '0;

        // rst en flt clr dt cmp hi lo fa
        vecs.push_back(mk(0, 1, 0, 0, 2, 3'b101, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2, 3'b101, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2, 3'b101, 3'b000, 3'b000, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, 2, 3'b101, 3'b000, 3'b000, 0));
        vecs.push_back(mk(1, 1, 0, 0, 2, 3'b101, 3'b101, 3'b010, 0));
        vecs.push_back(mk(1, 1, 0, 0, 2, 3'b101, 3'b101, 3'b010, 0));
        // all legs to LO_ON with dead_time 4
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 0, 0, 4, 3'b000, 3'b000, 3'b010, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4, 3'b000, 3'b000, 3'b111, 0));
        // leg0 low->high: five both-off cycles
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 0, 0, 4, 3'b001, 3'b000, 3'b110, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4, 3'b001, 3'b001, 3'b110, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4, 3'b001, 3'b001, 3'b110, 0));
        // two-cycle low glitch absorbed; dead_time change mid-interval ignored
        vecs.push_back(mk(1, 1, 0, 0, 4, 3'b000, 3'b000, 3'b110, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4, 3'b000, 3'b000, 3'b110, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4, 3'b001, 3'b000, 3'b110, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 1, 0, 0, 9, 3'b001, 3'b000, 3'b110, 0));
        vecs.push_back(mk(1, 1, 0, 0, 9, 3'b001, 3'b001, 3'b110, 0));
        // dead_time 0 with toggling comparators: no gate turns on
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b111, 3'b001, 3'b000, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 1, 0, 0, 0, (i % 2 == 0) ? 3'b000 : 3'b111, 3'b000, 3'b000, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            inv_on = 1'b1;
        end

        // fault during HI_ON with clock enable low
        apply(mk(1, 1, 0, 0, 0, 3'b111, 3'b000, 3'b000, 0));
        apply(mk(1, 1, 0, 0, 0, 3'b111, 3'b111, 3'b000, 0));
        apply(mk(1, 0, 1, 0, 3, 3'b111, 3'b000, 3'b000, 1));
        apply(mk(1, 0, 1, 1, 3, 3'b111, 3'b000, 3'b000, 1));
`ifdef DTI_FAULT_LATCH_EN
        for (int i = 0; i < 3; i++) apply(mk(1, 1, 0, 0, 3, 3'b111, 3'b000, 3'b000, 1));
        apply(mk(1, 1, 0, 1, 3, 3'b111, 3'b000, 3'b000, 0));
`else
        apply(mk(1, 1, 0, 0, 3, 3'b111, 3'b000, 3'b000, 0));
`endif
        apply(mk(1, 1, 0, 1, 3, 3'b111, 3'b000, 3'b000, 0));
        apply(mk(1, 1, 0, 0, 3, 3'b111, 3'b000, 3'b000, 0));
        apply(mk(1, 1, 0, 0, 3, 3'b111, 3'b000, 3'b000, 0));
        apply(mk(1, 1, 0, 0, 3, 3'b111, 3'b111, 3'b000, 0));

        // clock enable low mid dead interval freezes the count
        apply(mk(1, 1, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
        apply(mk(1, 1, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0));
        for (int i = 0; i < 3; i++) apply(mk(1, 1, 0, 0, 4, 3'b111, 3'b000, 3'b000, 0));
        for (int i = 0; i < 10; i++)
            apply(mk(1, 0, 0, 0, i, (i % 2 == 1) ? 3'b000 : 3'b111, 3'b000, 3'b000, 0));
        apply(mk(1, 1, 0, 0, 4, 3'b111, 3'b000, 3'b000, 0));
        apply(mk(1, 1, 0, 0, 4, 3'b111, 3'b000, 3'b000, 0));
        apply(mk(1, 1, 0, 0, 4, 3'b111, 3'b111, 3'b000, 0));
        for (int i = 0; i < 3; i++) apply(mk(1, 0, 0, 0, 4, 3'b000, 3'b111, 3'b000, 0));
        apply(mk(1, 1, 0, 0, 4, 3'b000, 3'b000, 3'b000, 0));

        // random comparator activity, overlap monitor only
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            clk_enable = ($urandom_range(0, 7) != 0);
            dead_time  = 8'($urandom_range(0, 2));
            cmp_in     = 3'($urandom_range(0, 7));
            fault      = ($urandom_range(0, 15) == 0);
        end

        // reset outranks fault
        apply(mk(0, 1, 1, 0, 0, 3'b111, 3'b000, 3'b000, 0));

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
